expr_eval_stream: RTL

EXPR_EVAL_STREAM -- requirements
Module: expr_eval_stream

---
 rtl/expr_eval_stream.sv | 348 ++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/expr_eval_stream.sv
// expr_eval_stream: evaluates a streamed ASCII infix expression (digits, + - *,
// parentheses, unary minus, '=' terminator) with a value stack and an operator
// stack, and presents one WIDTH-bit two's-complement result per expression.
//
// state  | meaning
// ACCEPT | taking characters, building literals, pushing tokens
// REDUCE | applying one operator per cycle for an incoming operator or ')'
// FLUSH  | '=' seen, reducing one operator per cycle until the op stack is empty
// DONE   | result presented, waiting for out_ready
// DRAIN  | error latched, discarding characters until '='
module expr_eval_stream #(
  parameter int WIDTH     = 50,
  parameter int VAL_DEPTH = 16,
  parameter int OP_DEPTH  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_char,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_value,
  output logic [1:0]       out_error,
  output logic             busy
);

  localparam int VCW = $clog2(VAL_DEPTH + 1);
  localparam int OCW = $clog2(OP_DEPTH + 1);
  localparam int VIW = (VAL_DEPTH > 1) ? $clog2(VAL_DEPTH) : 1;
  localparam int OIW = (OP_DEPTH > 1) ? $clog2(OP_DEPTH) : 1;
  localparam logic [VCW-1:0] VAL_FULL = VCW'(VAL_DEPTH);
  localparam logic [OCW-1:0] OP_FULL  = OCW'(OP_DEPTH);

  localparam logic [1:0] OP_ADD  = 2'd0;
  localparam logic [1:0] OP_SUB  = 2'd1;
  localparam logic [1:0] OP_MUL  = 2'd2;
  localparam logic [1:0] OP_LPAR = 2'd3;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_OVF  = 2'd1;
  localparam logic [1:0] ERR_SYN  = 2'd2;
  localparam logic [1:0] ERR_CHAR = 2'd3;

  typedef enum logic [2:0] {ACCEPT, REDUCE, FLUSH, DONE, DRAIN} state_t;
  state_t state, stateNext;

  logic [WIDTH-1:0] valStack [VAL_DEPTH];
  logic [1:0]       opStack  [OP_DEPTH];
  logic [VCW-1:0]   valCnt;
  logic [OCW-1:0]   opCnt;

  logic [WIDTH-1:0] acc, accNext, accStep, litVal;
  logic             litPending, litPendingNext;
  logic             signPending, signPendingNext;
  logic             expectOperand, expectOperandNext;
  logic             gotToken, gotTokenNext;
  logic             parenMode, parenModeNext;
  logic [1:0]       pendOp, pendOpNext;
  logic [1:0]       errCode, errNext, accErr;
  logic [WIDTH-1:0] resValue, resNext;
  logic             busyReg, busyNext;

  logic             pushVal, pushOp, popOp, doReduce, clearStacks;
  logic [WIDTH-1:0] pushValData;
  logic [1:0]       pushOpData;

  logic [VIW-1:0]   valTopIdx, valSecIdx, valPushIdx;
  logic [OIW-1:0]   opTopIdx, opPushIdx;
  logic [1:0]       opTop, newOp;
  logic [WIDTH-1:0] valA, valB, redResult;
  logic             valFull, opFull, opEmpty, valHas2;
  logic             topReducesNew, topReducesPend;
  logic             isDigit, isPlus, isMinus, isMul, isLpar, isRpar, isSpace, isEq;

  // '*' binds tighter than '+' and '-'
  function automatic logic precOf(input logic [1:0] op);
    return op == OP_MUL;
  endfunction

  // Stack pointers, top-of-stack operands, reduction result and character class
  always_comb begin
    valTopIdx  = VIW'(valCnt - VCW'(1));
    valSecIdx  = VIW'(valCnt - VCW'(2));
    valPushIdx = VIW'(valCnt);
    opTopIdx   = OIW'(opCnt - OCW'(1));
    opPushIdx  = OIW'(opCnt);
    valFull    = (valCnt == VAL_FULL);
    opFull     = (opCnt == OP_FULL);
    opEmpty    = (opCnt == '0);
    valHas2    = (valCnt >= VCW'(2));
    opTop      = opStack[opTopIdx];
    valA       = valStack[valSecIdx];
    valB       = valStack[valTopIdx];
    case (opTop)
      OP_ADD:  redResult = valA + valB;
      OP_SUB:  redResult = valA - valB;
      default: redResult = valA * valB;
    endcase
    accStep = acc * WIDTH'(10) + WIDTH'(in_char[3:0]);
    litVal  = signPending ? -acc : acc;
    isDigit = (in_char >= 8'h30) && (in_char <= 8'h39);
    isPlus  = (in_char == 8'h2B);
    isMinus = (in_char == 8'h2D);
    isMul   = (in_char == 8'h2A);
    isLpar  = (in_char == 8'h28);
    isRpar  = (in_char == 8'h29);
    isSpace = (in_char == 8'h20);
    isEq    = (in_char == 8'h3D);
    newOp   = isPlus ? OP_ADD : (isMinus ? OP_SUB : OP_MUL);
    topReducesNew  = !opEmpty && (opTop != OP_LPAR) && (precOf(opTop) >= precOf(newOp));
    topReducesPend = !opEmpty && (opTop != OP_LPAR) && (precOf(opTop) >= precOf(pendOp));
  end

  // Next-state, stack commands and handshake outputs
  always_comb begin
    stateNext         = state;
    accNext           = acc;
    litPendingNext    = litPending;
    signPendingNext   = signPending;
    expectOperandNext = expectOperand;
    gotTokenNext      = gotToken;
    parenModeNext     = parenMode;
    pendOpNext        = pendOp;
    errNext           = errCode;
    resNext           = resValue;
    busyNext          = busyReg;
    pushVal           = 1'b0;
    pushValData       = litVal;
    pushOp            = 1'b0;
    pushOpData        = newOp;
    popOp             = 1'b0;
    doReduce          = 1'b0;
    clearStacks       = 1'b0;
    accErr            = ERR_NONE;
    in_ready          = 1'b0;
    out_valid         = 1'b0;
    unique case (state)
      ACCEPT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          busyNext = 1'b1;
          if (isDigit) begin
            if (litPending) begin
              accNext = accStep;
            end else if (expectOperand) begin
              accNext           = WIDTH'(in_char[3:0]);
              litPendingNext    = 1'b1;
              expectOperandNext = 1'b0;
              gotTokenNext      = 1'b1;
            end else begin
              accErr = ERR_SYN;
            end
          end else begin
            // Any non-digit closes the literal being built
            if (litPending) begin
              pushVal         = 1'b1;
              accNext         = '0;
              litPendingNext  = 1'b0;
              signPendingNext = 1'b0;
            end
            if (isSpace) begin
              accErr = ERR_NONE;
            end else if (isMinus && expectOperand) begin
              gotTokenNext = 1'b1;
              if (signPending) accErr = ERR_SYN;
              else signPendingNext = 1'b1;
            end else if (isPlus || isMinus || isMul) begin
              gotTokenNext = 1'b1;
              if (expectOperand) begin
                accErr = ERR_SYN;
              end else begin
                expectOperandNext = 1'b1;
                if (topReducesNew) begin
                  stateNext     = REDUCE;
                  pendOpNext    = newOp;
                  parenModeNext = 1'b0;
                end else begin
                  pushOp = 1'b1;
                end
              end
            end else if (isLpar) begin
              gotTokenNext = 1'b1;
              if (!expectOperand || signPending) begin
                accErr = ERR_SYN;
              end else begin
                pushOp     = 1'b1;
                pushOpData = OP_LPAR;
              end
            end else if (isRpar) begin
              gotTokenNext = 1'b1;
              if (expectOperand) begin
                accErr = ERR_SYN;
              end else begin
                stateNext     = REDUCE;
                parenModeNext = 1'b1;
              end
            end else if (isEq) begin
              if (!gotToken) accErr = ERR_SYN;
              else stateNext = FLUSH;
            end else begin
              accErr = ERR_CHAR;
            end
            if ((accErr == ERR_NONE) && ((pushVal && valFull) || (pushOp && opFull)))
              accErr = ERR_OVF;
          end
          // An erroring character leaves every stack and token flag untouched
          if (accErr != ERR_NONE) begin
            accNext           = acc;
            litPendingNext    = litPending;
            signPendingNext   = signPending;
            expectOperandNext = expectOperand;
            gotTokenNext      = gotToken;
            parenModeNext     = parenMode;
            pendOpNext        = pendOp;
            pushVal           = 1'b0;
            pushOp            = 1'b0;
            errNext           = accErr;
            resNext           = '0;
            stateNext         = isEq ? DONE : DRAIN;
          end
        end
      end
      REDUCE: begin
        if (parenMode) begin
          if (opEmpty) accErr = ERR_SYN;
          else if (opTop == OP_LPAR) begin
            popOp     = 1'b1;
            stateNext = ACCEPT;
          end else if (!valHas2) accErr = ERR_SYN;
          else doReduce = 1'b1;
        end else if (topReducesPend) begin
          if (!valHas2) accErr = ERR_SYN;
          else doReduce = 1'b1;
        end else if (opFull) begin
          accErr = ERR_OVF;
        end else begin
          pushOp     = 1'b1;
          pushOpData = pendOp;
          stateNext  = ACCEPT;
        end
        if (accErr != ERR_NONE) begin
          errNext   = accErr;
          resNext   = '0;
          stateNext = DRAIN;
        end
      end
      FLUSH: begin
        // The empty-stack check costs its own cycle, giving 1 + R latency
        if (opEmpty) begin
          if (valCnt == VCW'(1)) begin
            stateNext = DONE;
            resNext   = valStack[0];
          end else accErr = ERR_SYN;
        end else if (opTop == OP_LPAR) accErr = ERR_SYN;
        else if (!valHas2) accErr = ERR_SYN;
        else doReduce = 1'b1;
        if (accErr != ERR_NONE) begin
          errNext   = accErr;
          resNext   = '0;
          stateNext = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          stateNext         = ACCEPT;
          clearStacks       = 1'b1;
          accNext           = '0;
          litPendingNext    = 1'b0;
          signPendingNext   = 1'b0;
          expectOperandNext = 1'b1;
          gotTokenNext      = 1'b0;
          parenModeNext     = 1'b0;
          errNext           = ERR_NONE;
          resNext           = '0;
          busyNext          = 1'b0;
        end
      end
      DRAIN: begin
        in_ready = 1'b1;
        if (in_valid) begin
          busyNext = 1'b1;
          if (isEq) stateNext = DONE;
        end
      end
      default: stateNext = ACCEPT;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACCEPT;
    else     state <= stateNext;
  end

  // Token flags, result, error and stack depth counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valCnt        <= '0;
      opCnt         <= '0;
      acc           <= '0;
      litPending    <= 1'b0;
      signPending   <= 1'b0;
      expectOperand <= 1'b1;
      gotToken      <= 1'b0;
      parenMode     <= 1'b0;
      pendOp        <= OP_ADD;
      errCode       <= ERR_NONE;
      resValue      <= '0;
      busyReg       <= 1'b0;
    end else begin
      acc           <= accNext;
      litPending    <= litPendingNext;
      signPending   <= signPendingNext;
      expectOperand <= expectOperandNext;
      gotToken      <= gotTokenNext;
      parenMode     <= parenModeNext;
      pendOp        <= pendOpNext;
      errCode       <= errNext;
      resValue      <= resNext;
      busyReg       <= busyNext;
      if (clearStacks) begin
        valCnt <= '0;
        opCnt  <= '0;
      end else if (doReduce) begin
        valCnt <= valCnt - VCW'(1);
        opCnt  <= opCnt - OCW'(1);
      end else begin
        if (pushVal) valCnt <= valCnt + VCW'(1);
        if (pushOp)     opCnt <= opCnt + OCW'(1);
        else if (popOp) opCnt <= opCnt - OCW'(1);
      end
    end
  end

  // Stack storage; depth counters alone decide what is live
  always_ff @(posedge clk) begin
    if (doReduce)     valStack[valSecIdx]  <= redResult;
    else if (pushVal) valStack[valPushIdx] <= pushValData;
    if (pushOp)       opStack[opPushIdx]   <= pushOpData;
  end

  assign out_value = resValue;
  assign out_error = errCode;
  assign busy      = busyReg;

endmodule
